// File: rtl/uart_rx_mmio_if.sv
// -----------------------------------------------------------------------------
// uart_rx_mmio_if
// Read-side dmem bus between the core and the memory-mapped UART receiver.
//   addr   core -> dev  32  byte address from the core
//   rdEn   core -> dev   1  one-cycle read strobe qualifying addr
//   rData  dev  -> core 32  read data, combinational from addr
//   hit    dev  -> core  1  addr decodes to one of the receiver's registers
// -----------------------------------------------------------------------------
interface uart_rx_mmio_if;
  logic [31:0] addr;
  logic        rdEn;
  logic [31:0] rData;
  logic        hit;

  modport master (
    output addr,
    output rdEn,
    input  rData,
    input  hit
  );

  modport slave (
    input  addr,
    input  rdEn,
    output rData,
    output hit
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// -----------------------------------------------------------------------------
// uart_rx_mmio
// Memory-mapped 8N1 UART receiver. The serial line is synchronised,
// deserialised by a mid-bit sampling FSM and queued in a small FIFO. The core
// reads bytes and status through the dmem read path.
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-low
//   rx    in   asynchronous serial input, idle high
//   bus   slave modport: addr/rdEn in, rData/hit out
// Register map:
//   DATA_ADDR  read pops the head byte -> {24'b0, byte}, 0 when empty
//   STAT_ADDR  {28'b0, ferr, ovr, full, !empty}; a strobed read clears ferr/ovr
// -----------------------------------------------------------------------------
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] DATA_ADDR    = 32'hFFFF_FFF8,
  parameter logic [31:0] STAT_ADDR    = 32'hFFFF_FFF4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_mmio_if.slave  bus
);

  localparam int CNT_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int HALF_LAST_I = CLKS_PER_BIT / 2 - 1;
  localparam int BIT_LAST_I  = CLKS_PER_BIT - 1;

  localparam logic [CNT_W-1:0] HALF_LAST = HALF_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] BIT_LAST  = BIT_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   COUNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } stateT;

  // ---------------------------------------------------------------------------
  // Input synchroniser; both flops reset to the idle line level so a reset
  // never manufactures a start bit.
  // ---------------------------------------------------------------------------
  logic rxMeta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours (rxs gets the old rxMeta).
      rxMeta <= rx;
      rxs    <= rxMeta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [2:0]       idx;
  logic [2:0]       idxNext;
  logic [7:0]       sh;
  logic [7:0]       shNext;
  logic             stopOk;
  logic             stopBad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      idx   <= idxNext;
      sh    <= shNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    stateNext = state;
    cntNext   = cnt + CNT_ONE;
    idxNext   = idx;
    shNext    = sh;
    stopOk    = 1'b0;
    stopBad   = 1'b0;

    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (!rxs) stateNext = START;
      end

      // Half a bit after the falling edge we are mid start bit; a high line
      // there means the edge was noise.
      START: begin
        if (cnt == HALF_LAST) begin
          cntNext   = '0;
          idxNext   = '0;
          stateNext = rxs ? IDLE : DATA;
        end
      end

      // From mid start bit, a full bit period lands on mid data bit.
      DATA: begin
        if (cnt == BIT_LAST) begin
          cntNext = '0;
          shNext  = {rxs, sh[7:1]};
          idxNext = idx + 3'd1;
          if (idx == 3'd7) stateNext = STOP;
        end
      end

      // Return to IDLE at mid stop bit so the next start edge is not missed.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cntNext   = '0;
          stateNext = IDLE;
          stopOk    = rxs;
          stopBad   = !rxs;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic dataSel;
  logic statSel;
  logic statRd;
  logic pop;
  logic push;
  logic ovrSet;
  logic full;
  logic empty;

  assign dataSel = (bus.addr == DATA_ADDR);
  assign statSel = (bus.addr == STAT_ADDR);
  assign bus.hit = dataSel | statSel;
  assign statRd  = bus.rdEn & statSel;
  assign pop     = bus.rdEn & dataSel & !empty;

  // A pop in the same cycle frees the slot the new byte needs.
  assign push    = stopOk & (!full | pop);
  assign ovrSet  = stopOk & full & !pop;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set on the same edge as a status read wins, so an
  // error is never lost between the read data and the clear.
  // ---------------------------------------------------------------------------
  logic ovr;
  logic ferr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (ovrSet)      ovr <= 1'b1;
      else if (statRd) ovr <= 1'b0;

      if (stopBad)     ferr <= 1'b1;
      else if (statRd) ferr <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: pure function of addr and current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.rData = '0;
    if (dataSel) begin
      if (!empty) bus.rData = {24'b0, mem[rdPtr]};
    end else if (statSel) begin
      bus.rData = {28'b0, ferr, ovr, full, !empty};
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_mmio
// Self-checking bench for uart_rx_mmio (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// Expected register values come from a byte queue plus two sticky flags
// updated per whole frame and per bus read.
// -----------------------------------------------------------------------------
module tb_uart_rx_mmio;

  localparam int          CLKS   = 8;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] DATA_A = 32'hFFFF_FFF8;
  localparam logic [31:0] STAT_A = 32'hFFFF_FFF4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  uart_rx_mmio_if busIf ();

  uart_rx_mmio #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (DEPTH),
    .DATA_ADDR    (DATA_A),
    .STAT_ADDR    (STAT_A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (busIf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  byte unsigned modelQ[$];
  bit           modelOvr  = 1'b0;
  bit           modelFerr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expStat();
    logic isFull;
    logic notEmpty;
    isFull   = (modelQ.size() == DEPTH);
    notEmpty = (modelQ.size() != 0);
    return {28'b0, modelFerr, modelOvr, isFull, notEmpty};
  endfunction

  function automatic logic [31:0] expData();
    if (modelQ.size() == 0) return 32'h0;
    return {24'b0, modelQ[0]};
  endfunction

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame. With popAtStop the DATA register is strobed in the cycle
  // that ends on the stop-bit sample edge.
  task automatic sendFrame(input byte unsigned data, input bit stopBit, input bit popAtStop);
    rx = 1'b0;
    step(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      step(CLKS);
    end
    rx = stopBit;
    if (!popAtStop) begin
      step(CLKS);
    end else begin
      step(CLKS - 2);
      busIf.addr = DATA_A;
      busIf.rdEn = 1'b1;
      #1;
      check("popAtStop data", busIf.rData, expData());
      step(1);
      busIf.rdEn = 1'b0;
      busIf.addr = 32'h0;
      step(1);
    end
    rx = 1'b1;
    if (popAtStop && modelQ.size() != 0) void'(modelQ.pop_front());
    if (stopBit) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(data);
      else                       modelOvr = 1'b1;
    end else begin
      modelFerr = 1'b1;
    end
    // A framing error leaves the line low at the stop sample; give the FSM
    // time to reject that tail before the next start edge.
    step(stopBit ? 2 : 2 * CLKS);
  endtask

  task automatic readStat(input string tag);
    busIf.addr = STAT_A;
    busIf.rdEn = 1'b1;
    #1;
    check(tag, busIf.rData, expStat());
    step(1);
    busIf.rdEn = 1'b0;
    busIf.addr = 32'h0;
    modelOvr   = 1'b0;
    modelFerr  = 1'b0;
  endtask

  task automatic readData(input string tag);
    busIf.addr = DATA_A;
    busIf.rdEn = 1'b1;
    #1;
    check(tag, busIf.rData, expData());
    step(1);
    busIf.rdEn = 1'b0;
    busIf.addr = 32'h0;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
  endtask

  // Status without a strobe: must not disturb the flags.
  task automatic peekStat(input string tag);
    busIf.addr = STAT_A;
    busIf.rdEn = 1'b0;
    #1;
    check(tag, busIf.rData, expStat());
    check("stat hit", {31'b0, busIf.hit}, 32'h1);
    busIf.addr = 32'h0;
    #1;
  endtask

  // Strobed read of an unmapped address: no hit, zero data, no side effect.
  task automatic strayRead(input logic [31:0] a);
    busIf.addr = a;
    busIf.rdEn = 1'b1;
    #1;
    check("stray hit", {31'b0, busIf.hit}, 32'h0);
    check("stray data", busIf.rData, 32'h0);
    step(1);
    busIf.rdEn = 1'b0;
    busIf.addr = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    busIf.addr = 32'h0;
    busIf.rdEn = 1'b0;
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // Reset state
    peekStat("reset stat");
    busIf.addr = DATA_A;
    #1;
    check("reset data", busIf.rData, 32'h0);
    check("reset data hit", {31'b0, busIf.hit}, 32'h1);
    busIf.addr = 32'h0;
    #1;
    check("idle addr hit", {31'b0, busIf.hit}, 32'h0);

    // 1: single good byte
    sendFrame(8'h55, 1'b1, 1'b0);
    readStat("t1 stat");
    readData("t1 data");
    readStat("t1 stat after");

    // 2: short glitch on the line
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2 * CLKS);
    readStat("t2 stat");
    readData("t2 data empty");

    // 3: framing error
    sendFrame(8'hA3, 1'b0, 1'b0);
    readStat("t3 stat");
    readStat("t3 stat cleared");

    // 4: overrun with no reads
    for (int b = 1; b <= 5; b++) sendFrame(byte'(b), 1'b1, 1'b0);
    peekStat("t4 stat full");
    strayRead(DATA_A + 32'd4);
    peekStat("t4 stat after stray");
    for (int k = 0; k < 4; k++) readData("t4 data");
    readStat("t4 stat drained");
    readStat("t4 stat cleared");

    // 5: push into a full FIFO while popping on the same edge
    for (int b = 0; b < 4; b++) sendFrame(byte'(8'h10 + b), 1'b1, 1'b0);
    peekStat("t5 stat full");
    sendFrame(8'h99, 1'b1, 1'b1);
    peekStat("t5 stat no ovr");
    for (int k = 0; k < 4; k++) readData("t5 data");
    readStat("t5 stat end");

    // 6: reset in the middle of a frame
    sendFrame(8'h77, 1'b1, 1'b0);
    rx = 1'b0;
    step(CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      step(CLKS);
    end
    rx = 1'b1;
    step(CLKS / 2);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    modelQ.delete();
    modelOvr  = 1'b0;
    modelFerr = 1'b0;
    step(2);
    peekStat("t6 stat after reset");
    sendFrame(8'h3C, 1'b1, 1'b0);
    peekStat("t6 stat");
    readData("t6 data");
    readStat("t6 stat end");

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      byte unsigned d;
      bit           good;
      int unsigned  act;
      d    = byte'($urandom);
      good = ($urandom_range(0, 5) != 0);
      sendFrame(d, good, 1'b0);
      act = $urandom_range(0, 4);
      case (act)
        1: readData("rnd data");
        2: readStat("rnd stat");
        3: strayRead(32'h1000_0000 | ($urandom & 32'h0FFF_FFFF));
        4: begin
          readData("rnd data a");
          readData("rnd data b");
        end
        default: peekStat("rnd peek");
      endcase
    end
    while (modelQ.size() != 0) readData("drain data");
    readStat("final stat");
    readStat("final stat cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
